// File: rtl/dmem_boot_loader_if.sv
// dmem_boot_loader_if: loader stream, CPU store port, data_mem port and loader status.
// slave is the controller side; master is whoever drives the stream and the CPU.
interface dmem_boot_loader_if #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_WORDS = 64
);
    localparam int CW = $clog2(MAX_WORDS + 1);
    logic              ext_start;
    logic [ADDR_W-1:0] ext_start_addr;
    logic              ext_valid;
    logic              ext_ready;
    logic [DATA_W-1:0] ext_data;
    logic              ext_last;
    logic              ext_run;
    logic              cpu_memwrite;
    logic [ADDR_W-1:0] cpu_adr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [2:0]        cpu_funct3;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_funct3;
    logic              cpu_hold;
    logic [CW-1:0]     load_count;
    logic              load_done;
    logic              limit_hit;
    modport slave (
        input  ext_start, ext_start_addr, ext_valid, ext_data, ext_last, ext_run,
        input  cpu_memwrite, cpu_adr, cpu_wdata, cpu_funct3,
        output ext_ready, mem_we, mem_adr, mem_wdata, mem_funct3,
        output cpu_hold, load_count, load_done, limit_hit
    );
    modport master (
        output ext_start, ext_start_addr, ext_valid, ext_data, ext_last, ext_run,
        output cpu_memwrite, cpu_adr, cpu_wdata, cpu_funct3,
        input  ext_ready, mem_we, mem_adr, mem_wdata, mem_funct3,
        input  cpu_hold, load_count, load_done, limit_hit
    );
endinterface

// File: rtl/dmem_boot_loader.sv
// dmem_boot_loader: streams a boot image into data memory while holding the CPU,
// then hands the memory port to the CPU as a pure pass-through.
module dmem_boot_loader #(
    parameter int         DATA_W    = 32,
    parameter int         ADDR_W    = 32,
    parameter int         MAX_WORDS = 64,
    parameter logic [2:0] STORE_F3  = 3'b010
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_boot_loader_if.slave    bus
);
    localparam int CW = $clog2(MAX_WORDS + 1);
    typedef enum logic [1:0] {IDLE, LOAD, DONE, RUN} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              hit_q, hit_d;
    logic              first_q, first_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              run;
    logic              start;
    logic              final_beat;
    assign run        = state_q == RUN;
    assign start      = bus.ext_start && (state_q == IDLE || state_q == DONE);
    assign final_beat = bus.ext_last || cnt_q == CW'(MAX_WORDS - 1);
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        hit_d   = hit_q;
        first_d = 1'b0;
        we_d    = 1'b0;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        if (start) begin
            state_d = LOAD;
            addr_d  = bus.ext_start_addr & ~ADDR_W'(3);
            cnt_d   = '0;
            done_d  = 1'b0;
            hit_d   = 1'b0;
        end else if (state_q == LOAD && bus.ext_valid) begin
            we_d    = 1'b1;
            adr_d   = addr_q;
            wdata_d = bus.ext_data;
            addr_d  = addr_q + ADDR_W'(4);
            cnt_d   = cnt_q == CW'(MAX_WORDS) ? cnt_q : cnt_q + CW'(1);
            if (final_beat) begin
                state_d = DONE;
                done_d  = 1'b1;
                hit_d   = !bus.ext_last;
                first_d = 1'b1;
            end
        end else if (bus.ext_run && (state_q == IDLE || (state_q == DONE && !first_q))) begin
            // the first DONE cycle carries the final write, so release waits one cycle
            state_d = RUN;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            hit_q   <= 1'b0;
            first_q <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            hit_q   <= hit_d;
            first_q <= first_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
        end
    end
    assign bus.ext_ready  = state_q == LOAD;
    assign bus.cpu_hold   = !run;
    assign bus.mem_we     = run ? bus.cpu_memwrite : we_q;
    assign bus.mem_adr    = run ? bus.cpu_adr : adr_q;
    assign bus.mem_wdata  = run ? bus.cpu_wdata : wdata_q;
    assign bus.mem_funct3 = run ? bus.cpu_funct3 : STORE_F3;
    assign bus.load_count = cnt_q;
    assign bus.load_done  = done_q;
    assign bus.limit_hit  = hit_q;
endmodule

// File: doc/dmem_boot_loader.md
Name: dmem_boot_loader

Overview:
- Parametrised data-memory access controller between riscv_cpu and data_mem.
- Replaces the fixed "external write while in reset" mux with a handshaked streaming loader: an auto-incrementing address, a word-count limit, a hold on the CPU, and an explicit hand-over from load mode to run mode.
- In RUN, the memory port is passed through from the CPU unchanged.

Parameters:
- DATA_W, 32, data word width in bits.
- ADDR_W, 32, address width in bits.
- MAX_WORDS, 64, maximum beats accepted per load burst, ≥1.
- STORE_F3, 3'b010, funct3 value driven to data_mem for loader writes (word store).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ext_start  in  1  pulse: latch ext_start_addr and open a load burst.
- ext_start_addr  in  ADDR_W  burst base address; bits [1:0] are forced to 0 on latch.
- ext_valid  in  1  ext_data is valid.
- ext_ready  out  1  loader can accept a beat.
- ext_data  in  DATA_W  word to store.
- ext_last  in  1  qualifies the final beat of a burst.
- ext_run  in  1  pulse: release the CPU.
- cpu_memwrite  in  1  CPU store strobe.
- cpu_adr  in  ADDR_W  CPU data address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_funct3  in  3  CPU store size (Instr[14:12]).
- mem_we  out  1  to data_mem MemWrite.
- mem_adr  out  ADDR_W  to data_mem address.
- mem_wdata  out  DATA_W  to data_mem write data.
- mem_funct3  out  3  to data_mem funct3.
- cpu_hold  out  1  holds riscv_cpu in reset; OR'd with reset at the top level.
- load_count  out  $clog2(MAX_WORDS+1)  beats accepted in the current burst.
- load_done  out  1  burst closed.
- limit_hit  out  1  burst closed by MAX_WORDS rather than ext_last; sticky until the next ext_start or reset.

Behaviour:
- Reset values (asynchronous):
  - state=IDLE, cpu_hold=1, ext_ready=0, mem_we=0.
  - mem_adr=0, mem_wdata=0, mem_funct3=STORE_F3.
  - load_count=0, load_done=0, limit_hit=0, internal address register=0.
- States: IDLE, LOAD, DONE, RUN.
- IDLE:
  - cpu_hold=1.
  - ext_start -> LOAD; latch the address; clear count, load_done and limit_hit.
  - Otherwise ext_run -> RUN. ext_start has priority if both are asserted.
- LOAD:
  - ext_ready=1.
  - Beat accepted when ext_valid&&ext_ready at a rising edge.
  - Each accepted beat:
    - registers mem_we=1, mem_adr=addr, mem_wdata=ext_data, mem_funct3=STORE_F3.
    - The write appears on the memory port the cycle after acceptance (latency 1). mem_we is a single-cycle pulse per beat.
    - addr += 4, wrapping modulo 2^ADDR_W; load_count += 1.
  - Accepted beat with ext_last=1 -> DONE, load_done=1.
  - Accepted beat that makes load_count==MAX_WORDS without ext_last -> DONE, load_done=1, limit_hit=1.
  - Accepted beat with ext_last=1 that also reaches the limit -> limit_hit=0 (ext_last wins).
  - ext_start during LOAD is ignored.
  - ext_run during LOAD is ignored; no early release.
  - Back-to-back beats give one write per cycle.
- DONE:
  - ext_ready=0, cpu_hold=1.
  - The final write issues in the first DONE cycle.
  - ext_start -> LOAD with a new base address; count cleared.
  - ext_run -> RUN, accepted only from the second DONE cycle onward so the final write always lands before release. An ext_run pulse in the first DONE cycle is ignored.
- RUN:
  - cpu_hold=0, ext_ready=0.
  - Combinational pass-through: mem_we=cpu_memwrite, mem_adr=cpu_adr, mem_wdata=cpu_wdata, mem_funct3=cpu_funct3.
  - ext_start, ext_valid and ext_run are ignored.
  - RUN is left only by reset.
- Outside RUN, when no loader write is being issued:
  - mem_we=0.
  - mem_adr holds the last value.
  - mem_funct3=STORE_F3.
  - CPU inputs are ignored, so a held CPU can never write.
- Reset mid-LOAD: the burst is aborted, a pending registered write is dropped (mem_we=0 immediately), and the block returns to IDLE.
- load_count saturates at MAX_WORDS; it never wraps.

Test Plan:
1. Reset, ext_start with addr=0x0000_0013, 3 beats (0x11,0x22,0x33; last on the third) -> writes at 0x10, 0x14, 0x18, one cycle after each handshake; load_count=3; load_done=1; limit_hit=0; cpu_hold=1.
2. MAX_WORDS=4, stream 6 beats with no ext_last -> exactly 4 writes; ext_ready drops after beat 4; limit_hit=1; beats 5–6 are never acknowledged.
3. After DONE, pulse ext_run in the first DONE cycle, then again later -> first pulse ignored; second moves to RUN; cpu_hold=0; cpu_memwrite=1, cpu_adr=0x40, cpu_funct3=3'b000 appear on the mem_* outputs the same cycle.
4. ext_start_addr=0xFFFF_FFFC with 2 beats -> writes at 0xFFFF_FFFC then 0x0000_0000.
5. Assert reset in the same cycle a beat is accepted during LOAD -> no mem_we pulse; state=IDLE; load_count=0; cpu_hold=1; cpu_memwrite is blocked in IDLE.
6. ext_valid toggling every other cycle during LOAD -> one write per handshake only; in DONE, a second ext_start to 0x100 restarts the count at 0.
